// File: rtl/feature2weight_hbm_packer_pkg.sv
// Shared constants and FSM state type for the feature-to-weight HBM packer.
package f2w_pkg;

    localparam int unsigned HBM_DW        = 256;
    localparam int unsigned T_QUANT_BLOCK = 128;
    localparam int unsigned WT_DW         = 4;
    localparam int unsigned SCALE_DW      = 16;
    localparam int unsigned GROUP_BLOCKS  = HBM_DW / SCALE_DW;
    localparam int unsigned BLK_BEATS     = T_QUANT_BLOCK * WT_DW / HBM_DW;

    typedef enum logic [1:0] {
        IDLE,
        WT,
        SC,
        FIN
    } state_t;

endpackage

// File: rtl/feature2weight_hbm_packer_out_slice.sv
// Single registered valid/ready stage carrying an HBM beat and its address.
module f2w_out_slice #(
    parameter int unsigned DW = 256,
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat,
    output logic [AW-1:0] out_addr
);

    // Accept a new beat whenever the register is empty or draining this cycle.
    assign in_rdy = !out_vld || out_rdy;

    // Load on accept, otherwise hold until the consumer takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_addr <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld  <= 1'b1;
            out_dat  <= in_dat;
            out_addr <= in_addr;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/feature2weight_hbm_packer.sv
// Packs INT4 weight beats and their per-block FP16 scales into a linear
// stream of HBM write beats: every group of up to GROUP_BLOCKS blocks is
// followed by one beat holding the group's scales.
module feature2weight_hbm_packer #(
    parameter int unsigned HBM_DW        = 256,
    parameter int unsigned T_QUANT_BLOCK = 128,
    parameter int unsigned WT_DW         = 4,
    parameter int unsigned SCALE_DW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [12:0]         cfg_blocks,
    input  logic [15:0]         cfg_rows,
    input  logic [31:0]         cfg_base_addr,
    input  logic                wt_vld,
    output logic                wt_rdy,
    input  logic [HBM_DW-1:0]   wt_dat,
    input  logic                sc_vld,
    output logic                sc_rdy,
    input  logic [SCALE_DW-1:0] sc_dat,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [HBM_DW-1:0]   out_dat,
    output logic [31:0]         out_addr,
    output logic                busy,
    output logic                done
);

    localparam int unsigned GROUP_BLOCKS = HBM_DW / SCALE_DW;
    localparam int unsigned BLK_BEATS    = T_QUANT_BLOCK * WT_DW / HBM_DW;
    localparam int unsigned BEAT_W       = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam int unsigned GRP_W        = $clog2(GROUP_BLOCKS) + 1;

    import f2w_pkg::*;

    state_t              state;
    logic [12:0]         blocks_q;
    logic [15:0]         rows_q;
    logic [12:0]         blk_cnt;
    logic [15:0]         row_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [GRP_W-1:0]    grp_cnt;
    logic [31:0]         addr;
    logic [HBM_DW-1:0]   scale_reg;

    logic                last_beat;
    logic                last_blk;
    logic                grp_full;
    logic                slice_rdy;
    logic                slice_vld;
    logic [HBM_DW-1:0]   slice_dat;
    logic                wt_fire;
    logic                sc_emit;

    // Handshake decode: the last beat of a block only moves together with its scale.
    always_comb begin
        last_beat = (beat_cnt == BEAT_W'(BLK_BEATS - 1));
        last_blk  = (blk_cnt + 13'd1 == blocks_q);
        grp_full  = (grp_cnt == GRP_W'(GROUP_BLOCKS - 1));
        wt_rdy    = (state == WT) && slice_rdy && (!last_beat || sc_vld);
        sc_rdy    = wt_rdy && last_beat;
        wt_fire   = wt_vld && wt_rdy;
        sc_emit   = (state == SC) && slice_rdy;
        slice_vld = wt_fire || sc_emit;
        slice_dat = (state == SC) ? scale_reg : wt_dat;
    end

    // Control FSM: walks blocks, groups and rows and maintains the beat address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            blocks_q  <= '0;
            rows_q    <= '0;
            blk_cnt   <= '0;
            row_cnt   <= '0;
            beat_cnt  <= '0;
            grp_cnt   <= '0;
            addr      <= '0;
            scale_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        blocks_q  <= cfg_blocks;
                        rows_q    <= cfg_rows;
                        addr      <= cfg_base_addr;
                        blk_cnt   <= '0;
                        row_cnt   <= '0;
                        beat_cnt  <= '0;
                        grp_cnt   <= '0;
                        scale_reg <= '0;
                        busy      <= 1'b1;
                        state     <= (cfg_blocks == 13'd0 || cfg_rows == 16'd0) ? FIN : WT;
                    end
                end
                WT: begin
                    if (wt_fire) begin
                        addr <= addr + 32'd32;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            scale_reg[SCALE_DW*grp_cnt +: SCALE_DW] <= sc_dat;
                            grp_cnt  <= grp_cnt + 1'b1;
                            blk_cnt  <= blk_cnt + 13'd1;
                            if (grp_full || last_blk) begin
                                state <= SC;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                SC: begin
                    if (sc_emit) begin
                        addr      <= addr + 32'd32;
                        scale_reg <= '0;
                        grp_cnt   <= '0;
                        if (blk_cnt == blocks_q) begin
                            blk_cnt <= '0;
                            if (row_cnt == rows_q - 16'd1) begin
                                state <= FIN;
                            end else begin
                                row_cnt <= row_cnt + 16'd1;
                                state   <= WT;
                            end
                        end else begin
                            state <= WT;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    f2w_out_slice #(
        .DW (HBM_DW),
        .AW (32)
    ) u_out_slice (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (slice_vld),
        .in_rdy   (slice_rdy),
        .in_dat   (slice_dat),
        .in_addr  (addr),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_dat  (out_dat),
        .out_addr (out_addr)
    );

endmodule

// File: tb/tb_feature2weight_hbm_packer.sv
// Self-checking bench for feature2weight_hbm_packer: a queue-based model of
// the expected beat stream plus directed scenarios and literal spot checks.
module tb_feature2weight_hbm_packer;

    localparam int HBM_DW   = 256;
    localparam int SCALE_DW = 16;
    localparam int GB       = 16;
    localparam int BB       = 2;
    localparam int BUDGET   = 3000;

    logic                clk;
    logic                rst;
    logic                start;
    logic [12:0]         cfg_blocks;
    logic [15:0]         cfg_rows;
    logic [31:0]         cfg_base_addr;
    logic                wt_vld;
    logic                wt_rdy;
    logic [HBM_DW-1:0]   wt_dat;
    logic                sc_vld;
    logic                sc_rdy;
    logic [SCALE_DW-1:0] sc_dat;
    logic                out_vld;
    logic                out_rdy;
    logic [HBM_DW-1:0]   out_dat;
    logic [31:0]         out_addr;
    logic                busy;
    logic                done;

    feature2weight_hbm_packer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_blocks    (cfg_blocks),
        .cfg_rows      (cfg_rows),
        .cfg_base_addr (cfg_base_addr),
        .wt_vld        (wt_vld),
        .wt_rdy        (wt_rdy),
        .wt_dat        (wt_dat),
        .sc_vld        (sc_vld),
        .sc_rdy        (sc_rdy),
        .sc_dat        (sc_dat),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_dat       (out_dat),
        .out_addr      (out_addr),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [HBM_DW-1:0] dat;
    } beat_t;

    beat_t               exp_q[$];
    logic [HBM_DW-1:0]   wt_q[$];
    logic [SCALE_DW-1:0] sc_q[$];

    int compared   = 0;
    int mismatched = 0;
    int out_idx    = 0;
    int done_cnt   = 0;
    int last_cyc   = 0;
    bit chk_en     = 1'b0;
    bit prev_stall = 1'b0;
    logic [HBM_DW-1:0] prev_dat;
    logic [31:0]       prev_addr;

    task automatic check(input string name, input logic [HBM_DW-1:0] act, input logic [HBM_DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [HBM_DW-1:0] wt_word(input int r, input int b, input int k);
        logic [HBM_DW-1:0] res;
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ (r << 16) ^ (b << 4) ^ k;
        for (int i = 0; i < 8; i++) res[32*i +: 32] = w + 32'(i * 32'h0101_0101);
        return res;
    endfunction

    function automatic logic [SCALE_DW-1:0] sc_word(input int r, input int b);
        return 16'(16'h3C00 + r * 37 + b);
    endfunction

    // Reference stream: each row is a series of groups of up to GB blocks;
    // every group is its weight beats followed by one beat of its scales.
    task automatic build(input int blocks, input int rows, input logic [31:0] base);
        logic [HBM_DW-1:0] sreg;
        int n;
        beat_t bt;
        exp_q.delete(); wt_q.delete(); sc_q.delete();
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int g = 0; g < blocks; g += GB) begin
                sreg = '0;
                for (int b = g; b < blocks && b < g + GB; b++) begin
                    for (int k = 0; k < BB; k++) begin
                        wt_q.push_back(wt_word(r, b, k));
                        bt.addr = base + 32'(32 * n);
                        bt.dat  = wt_word(r, b, k);
                        exp_q.push_back(bt);
                        n++;
                    end
                    sc_q.push_back(sc_word(r, b));
                    sreg[SCALE_DW*(b-g) +: SCALE_DW] = sc_word(r, b);
                end
                bt.addr = base + 32'(32 * n);
                bt.dat  = sreg;
                exp_q.push_back(bt);
                n++;
            end
        end
    endtask

    // Output compare: every accepted beat against the model, and stability while stalled.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (prev_stall) begin
                check("hold_vld", HBM_DW'(out_vld), HBM_DW'(1));
                check("hold_dat", out_dat, prev_dat);
                check("hold_addr", HBM_DW'(out_addr), HBM_DW'(prev_addr));
            end
            if (out_vld && out_rdy) begin
                if (out_idx < exp_q.size()) begin
                    check("beat_addr", HBM_DW'(out_addr), HBM_DW'(exp_q[out_idx].addr));
                    check("beat_dat", out_dat, exp_q[out_idx].dat);
                end else begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_beat: got beat %0d expected at most %0d beats", out_idx, exp_q.size());
                end
                out_idx++;
            end
            prev_stall = out_vld && !out_rdy;
            prev_dat   = out_dat;
            prev_addr  = out_addr;
            if (done) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_case(input int blocks, input int rows, input logic [31:0] base,
                            input bit rnd, input int lag, input int abort_at, input int restart_at);
        int wi, si, wait_cnt, cyc;
        bit last;
        build(blocks, rows, base);
        out_idx = 0; done_cnt = 0;
        chk_en = 1'b1;
        wi = 0; si = 0; wait_cnt = 0; cyc = 0;
        @(negedge clk);
        cfg_blocks = 13'(blocks); cfg_rows = 16'(rows); cfg_base_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", HBM_DW'(busy), HBM_DW'(1));
        while ((out_idx < exp_q.size() || done_cnt == 0 || busy) && cyc < BUDGET
               && !(abort_at >= 0 && out_idx >= abort_at)) begin
            out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wi < wt_q.size()) begin
                wt_vld = 1'b1; wt_dat = wt_q[wi]; last = (wi % BB == BB - 1);
            end else begin
                wt_vld = 1'b0; wt_dat = '0; last = 1'b0;
            end
            sc_vld = last && (wait_cnt >= lag);
            sc_dat = sc_vld ? sc_q[si] : '0;
            if (cyc == restart_at) begin
                start = 1'b1; cfg_blocks = 13'd5; cfg_base_addr = 32'hDEAD_0000;
            end
            #1;
            if (!last) check("sc_rdy_off", HBM_DW'(sc_rdy), HBM_DW'(0));
            if (wt_vld && wt_rdy) begin
                wi++;
                if (last) si++;
                wait_cnt = 0;
            end else if (last) begin
                wait_cnt++;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        last_cyc = cyc;
        wt_vld = 1'b0; sc_vld = 1'b0; out_rdy = 1'b1;
        if (cyc >= BUDGET) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: got %0d beats after %0d cycles expected %0d beats", out_idx, cyc, exp_q.size());
        end
        if (abort_at < 0) begin
            repeat (3) @(negedge clk);
            check("beat_count", HBM_DW'(out_idx), HBM_DW'(exp_q.size()));
            check("done_count", HBM_DW'(done_cnt), HBM_DW'(1));
            check("busy_end", HBM_DW'(busy), HBM_DW'(0));
            check("wt_consumed", HBM_DW'(wi), HBM_DW'(wt_q.size()));
            check("sc_consumed", HBM_DW'(si), HBM_DW'(sc_q.size()));
        end
        chk_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_vld"}, HBM_DW'(out_vld), HBM_DW'(0));
        check({tag, "_out_dat"}, out_dat, '0);
        check({tag, "_out_addr"}, HBM_DW'(out_addr), HBM_DW'(0));
        check({tag, "_wt_rdy"}, HBM_DW'(wt_rdy), HBM_DW'(0));
        check({tag, "_sc_rdy"}, HBM_DW'(sc_rdy), HBM_DW'(0));
        check({tag, "_busy"}, HBM_DW'(busy), HBM_DW'(0));
        check({tag, "_done"}, HBM_DW'(done), HBM_DW'(0));
    endtask

    task automatic zero_case(input int blocks, input int rows);
        exp_q.delete();
        out_idx = 0; done_cnt = 0; chk_en = 1'b1;
        @(negedge clk);
        cfg_blocks = 13'(blocks); cfg_rows = 16'(rows); cfg_base_addr = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_busy", HBM_DW'(busy), HBM_DW'(1));
        check("zero_done_early", HBM_DW'(done), HBM_DW'(0));
        @(negedge clk);
        #1;
        check("zero_done", HBM_DW'(done), HBM_DW'(1));
        check("zero_busy_drop", HBM_DW'(busy), HBM_DW'(0));
        @(negedge clk);
        #1;
        check("zero_done_pulse", HBM_DW'(done), HBM_DW'(0));
        repeat (2) @(negedge clk);
        check("zero_no_beats", HBM_DW'(out_idx), HBM_DW'(0));
        chk_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_blocks = '0; cfg_rows = '0; cfg_base_addr = '0;
        wt_vld = 1'b0; wt_dat = '0; sc_vld = 1'b0; sc_dat = '0; out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Literal pins on the reference model.
        build(2, 1, 32'h0);
        check("model_a_size", HBM_DW'(exp_q.size()), HBM_DW'(5));
        check("model_a_wt3_addr", HBM_DW'(exp_q[3].addr), HBM_DW'(32'h60));
        check("model_a_sc_addr", HBM_DW'(exp_q[4].addr), HBM_DW'(32'h80));
        check("model_a_sc_dat", exp_q[4].dat, {224'd0, 16'h3C01, 16'h3C00});
        build(16, 1, 32'h0);
        check("model_b_size", HBM_DW'(exp_q.size()), HBM_DW'(33));
        check("model_b_last_addr", HBM_DW'(exp_q[32].addr), HBM_DW'(32'h400));
        build(17, 2, 32'h0200_0000);
        check("model_c_size", HBM_DW'(exp_q.size()), HBM_DW'(72));
        check("model_c_sc2_addr", HBM_DW'(exp_q[35].addr), HBM_DW'(32'h0200_0460));
        check("model_c_sc2_dat", exp_q[35].dat, {240'd0, 16'h3C10});
        check("model_c_row2_addr", HBM_DW'(exp_q[36].addr), HBM_DW'(32'h0200_0480));
        build(2, 1, 32'hFFFF_FFC0);
        check("model_wrap_addr", HBM_DW'(exp_q[2].addr), HBM_DW'(32'h0));

        run_case(2, 1, 32'h0, 1'b0, 0, -1, -1);
        run_case(16, 1, 32'h0, 1'b0, 0, -1, -1);
        compared++;
        if (last_cyc > 36) begin
            mismatched++;
            $display("FAIL throughput: got %0d cycles expected at most 36", last_cyc);
        end
        run_case(17, 2, 32'h0200_0000, 1'b0, 0, -1, -1);
        run_case(17, 2, 32'h0200_0000, 1'b1, 3, -1, -1);
        zero_case(0, 3);
        zero_case(4, 0);
        run_case(17, 1, 32'h40, 1'b0, 0, -1, 20);

        run_case(16, 1, 32'h0, 1'b0, 0, 10, -1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("midrst");
        rst = 1'b0;
        run_case(16, 1, 32'h0, 1'b0, 0, -1, -1);

        run_case(2, 1, 32'hFFFF_FFC0, 1'b1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
